match_ctrl: RTL and testbench

Sequencing controller for the 64-entry matching memory of the data-driven processor pipeline. It accepts one token per handshake and samples the external tag-comparator FIRE vector. It then either reads out and deletes the partner entry (fire), allocates the lowest free entry (wait), or passes the token straight through (MF=0). It owns the entry VALID bitmap and sits between the firing-control input latch and the function-processing output latch.

---
 rtl/match_pkg.sv | 16 +
 rtl/lsb_enc.sv | 24 ++
 rtl/match_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_match_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// Shared definitions for the matching-memory sequencing controller.
// Holds the default memory geometry and the controller state encoding.
// Build option: MATCH_OVF_EN (see match_ctrl.sv) is not used here.
package match_pkg;

  localparam int unsigned DefEntries = 64;
  localparam int unsigned DefAddrW   = 6;

  // Controller states (IDLE, LOOKUP, WRITE, READ, EMIT).
  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLookup = 3'd1;
  localparam logic [2:0] StWrite  = 3'd2;
  localparam logic [2:0] StRead   = 3'd3;
  localparam logic [2:0] StEmit   = 3'd4;

endpackage

// File: rtl/lsb_enc.sv
// Lowest-set-bit priority encoder, purely combinational.
// Ports:
//   vec_i  - input bit vector
//   idx_o  - index of the lowest set bit (0 when none set)
//   any_o  - 1 when at least one bit of vec_i is set
module lsb_enc #(
  parameter int unsigned Width = 64,
  parameter int unsigned IdxW  = $clog2(Width)
) (
  input  logic [Width-1:0] vec_i,
  output logic [IdxW-1:0]  idx_o,
  output logic             any_o
);

  always_comb begin
    idx_o = '0;
    any_o = |vec_i;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = int'(Width) - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IdxW'(i);
    end
  end

endmodule

// File: rtl/match_ctrl.sv
// Sequencing controller for the matching memory. Accepts one token per
// handshake, samples the tag-comparator FIRE vector in LOOKUP and then
// reads/deletes the partner entry, allocates the lowest free entry, or
// passes the token through. Owns the entry VALID bitmap and population count.
// Build option: MATCH_OVF_EN - when defined a miss on a full memory emits an
// overflow token (out_ovf_o=1); otherwise the token is dropped and err_o set.
// Ports:
//   cp_i, mr_ni          - clock, asynchronous active-low reset
//   in_req_i/in_ack_o    - upstream handshake, in_mf_i sampled with in_ack_o
//   fire_i               - comparator hit vector, used in LOOKUP only
//   valid_o, count_o, full_o - occupancy bitmap, population, all-full flag
//   addr_o, wr_e_o, rd_e_o, del_o - memory address and one-cycle strobes
//   out_req_o/out_ack_i  - downstream handshake, out_pair_o/out_ovf_o tag it
//   err_o                - sticky drop / inconsistency flag
module match_ctrl
  import match_pkg::*;
#(
  parameter int unsigned Entries = DefEntries,
  parameter int unsigned AddrW   = DefAddrW
) (
  input  logic               cp_i,
  input  logic               mr_ni,
  input  logic               in_req_i,
  output logic               in_ack_o,
  input  logic               in_mf_i,
  input  logic [Entries-1:0] fire_i,
  output logic [Entries-1:0] valid_o,
  output logic [AddrW-1:0]   addr_o,
  output logic               wr_e_o,
  output logic               rd_e_o,
  output logic               del_o,
  output logic               out_req_o,
  input  logic               out_ack_i,
  output logic               out_pair_o,
  output logic               out_ovf_o,
  output logic               full_o,
  output logic [AddrW:0]     count_o,
  output logic               err_o
);

  localparam logic [AddrW:0] CountMax = (AddrW+1)'(Entries);

  logic [2:0]         state_q, state_d;
  logic               ack_q, ack_d;
  logic               mf_q, mf_d;
  logic [Entries-1:0] valid_q, valid_d;
  logic [AddrW:0]     count_q, count_d;
  logic [AddrW-1:0]   addr_q, addr_d;
  logic               wr_e_q, wr_e_d;
  logic               rd_e_q, rd_e_d;
  logic               out_req_q, out_req_d;
  logic               pair_q, pair_d;
  logic               full_q, full_d;
  logic               err_q, err_d;
`ifdef MATCH_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic [AddrW-1:0] hit_idx, free_idx;
  logic             hit_any, free_any;

  // Comparator hits on invalid entries are ignored.
  lsb_enc #(.Width(Entries), .IdxW(AddrW)) u_hit_enc (
    .vec_i (fire_i & valid_q),
    .idx_o (hit_idx),
    .any_o (hit_any)
  );

  lsb_enc #(.Width(Entries), .IdxW(AddrW)) u_free_enc (
    .vec_i (~valid_q),
    .idx_o (free_idx),
    .any_o (free_any)
  );

  always_comb begin
    state_d   = state_q;
    mf_d      = mf_q;
    valid_d   = valid_q;
    count_d   = count_q;
    addr_d    = addr_q;
    wr_e_d    = 1'b0;
    rd_e_d    = 1'b0;
    out_req_d = out_req_q;
    pair_d    = pair_q;
    err_d     = err_q;
`ifdef MATCH_OVF_EN
    ovf_d     = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (ack_q) begin
          state_d = StLookup;
          mf_d    = in_mf_i;
        end
      end
      StLookup: begin
        if (!mf_q) begin
          state_d   = StEmit;
          out_req_d = 1'b1;
          pair_d    = 1'b0;
        end else if (hit_any) begin
          state_d          = StRead;
          rd_e_d           = 1'b1;
          addr_d           = hit_idx;
          valid_d[hit_idx] = 1'b0;
          if (count_q == '0) err_d = 1'b1;
          else count_d = count_q - 1'b1;
        end else if (free_any) begin
          state_d           = StWrite;
          wr_e_d            = 1'b1;
          addr_d            = free_idx;
          valid_d[free_idx] = 1'b1;
          if (count_q == CountMax) err_d = 1'b1;
          else count_d = count_q + 1'b1;
        end else begin
`ifdef MATCH_OVF_EN
          state_d   = StEmit;
          out_req_d = 1'b1;
          pair_d    = 1'b0;
          ovf_d     = 1'b1;
`else
          state_d = StIdle;
          err_d   = 1'b1;
`endif
        end
      end
      StWrite: state_d = StIdle;
      StRead: begin
        state_d   = StEmit;
        out_req_d = 1'b1;
        pair_d    = 1'b1;
      end
      StEmit: begin
        if (out_ack_i) begin
          state_d   = StIdle;
          out_req_d = 1'b0;
          pair_d    = 1'b0;
`ifdef MATCH_OVF_EN
          ovf_d     = 1'b0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
    // Acknowledge one cycle early when returning to IDLE so a waiting token
    // is accepted in the first IDLE cycle.
    ack_d  = in_req_i && (state_d == StIdle) && !ack_q;
    full_d = (count_d == CountMax);
  end

  always_ff @(posedge cp_i or negedge mr_ni) begin
    if (!mr_ni) begin
      state_q   <= StIdle;
      ack_q     <= 1'b0;
      mf_q      <= 1'b0;
      valid_q   <= '0;
      count_q   <= '0;
      addr_q    <= '0;
      wr_e_q    <= 1'b0;
      rd_e_q    <= 1'b0;
      out_req_q <= 1'b0;
      pair_q    <= 1'b0;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      mf_q      <= mf_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      wr_e_q    <= wr_e_d;
      rd_e_q    <= rd_e_d;
      out_req_q <= out_req_d;
      pair_q    <= pair_d;
      full_q    <= full_d;
      err_q     <= err_d;
    end
  end

`ifdef MATCH_OVF_EN
  always_ff @(posedge cp_i or negedge mr_ni) begin
    if (!mr_ni) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end
  assign out_ovf_o = ovf_q;
`else
  assign out_ovf_o = 1'b0;
`endif

  assign in_ack_o   = ack_q;
  assign valid_o    = valid_q;
  assign count_o    = count_q;
  assign full_o     = full_q;
  assign addr_o     = addr_q;
  assign wr_e_o     = wr_e_q;
  assign rd_e_o     = rd_e_q;
  assign del_o      = rd_e_q;
  assign out_req_o  = out_req_q;
  assign out_pair_o = pair_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Directed bench for match_ctrl with a scoreboard of expected output tokens.
module tb_match_ctrl;

  localparam int KWrite = 0;
  localparam int KRead  = 1;
  localparam int KPass  = 2;
  localparam int KOvf   = 3;

  typedef struct packed {
    logic pair;
    logic ovf;
  } tok_t;

  logic        clk = 1'b0;
  logic        mr_n;
  logic        in_req, in_ack, in_mf;
  logic [63:0] fire, valid;
  logic [5:0]  addr;
  logic        wr_e, rd_e, del, out_req, out_ack, out_pair, out_ovf, full, err;
  logic [6:0]  count;

  tok_t        sb[$];
  logic [63:0] mv;
  int          checks = 0;
  int          fails  = 0;

  always #5 clk = ~clk;

  match_ctrl dut (
    .cp_i       (clk),
    .mr_ni      (mr_n),
    .in_req_i   (in_req),
    .in_ack_o   (in_ack),
    .in_mf_i    (in_mf),
    .fire_i     (fire),
    .valid_o    (valid),
    .addr_o     (addr),
    .wr_e_o     (wr_e),
    .rd_e_o     (rd_e),
    .del_o      (del),
    .out_req_o  (out_req),
    .out_ack_i  (out_ack),
    .out_pair_o (out_pair),
    .out_ovf_o  (out_ovf),
    .full_o     (full),
    .count_o    (count),
    .err_o      (err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted output token is compared with the scoreboard head.
  always @(negedge clk) begin
    if (mr_n && out_req && out_ack) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_req", 64'(out_req), 64'd0);
      end else begin
        tok_t e;
        e = sb.pop_front();
        chk("out_pair", 64'(out_pair), 64'(e.pair));
        chk("out_ovf", 64'(out_ovf), 64'(e.ovf));
      end
    end
  end

  function automatic int low_free(input logic [63:0] v);
    for (int i = 0; i < 64; i++) if (!v[i]) return i;
    return 0;
  endfunction

  // Issues one token and checks the strobes at T+2 (and output timing).
  task automatic issue(input logic mf, input logic [63:0] f, input int kind, input int ea);
    int n;
    @(negedge clk);
    in_req = 1'b1;
    in_mf  = mf;
    n = 0;
    while (!in_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ack) begin
      chk("in_ack_timeout", 64'd0, 64'd1);
      in_req = 1'b0;
      return;
    end
    in_req = 1'b0;
    fire   = f;
    @(negedge clk);   // T+1 LOOKUP
    chk("lookup_no_out_req", 64'(out_req), 64'd0);
    @(negedge clk);   // T+2
    fire = '0;
    case (kind)
      KWrite: begin
        mv[ea] = 1'b1;
        chk("wr_e", 64'(wr_e), 64'd1);
        chk("rd_e_on_write", 64'({rd_e, del}), 64'd0);
        chk("write_addr", 64'(addr), 64'(ea));
        chk("valid_after_write", valid, mv);
        chk("count_after_write", 64'(count), 64'($countones(mv)));
        @(negedge clk);
        chk("write_no_out_req", 64'(out_req), 64'd0);
      end
      KRead: begin
        mv[ea] = 1'b0;
        chk("rd_e_del", 64'({rd_e, del}), 64'd3);
        chk("wr_e_on_read", 64'(wr_e), 64'd0);
        chk("read_addr", 64'(addr), 64'(ea));
        chk("valid_after_read", valid, mv);
        chk("count_after_read", 64'(count), 64'($countones(mv)));
        chk("read_out_req_t2", 64'(out_req), 64'd0);
        @(negedge clk);
        chk("read_out_req_t3", 64'(out_req), 64'd1);
      end
      KPass: begin
        chk("pass_no_strobes", 64'({wr_e, rd_e, del}), 64'd0);
        chk("pass_out_req_t2", 64'(out_req), 64'd1);
        chk("pass_valid", valid, mv);
      end
      default: begin
        chk("ovf_no_strobes", 64'({wr_e, rd_e, del}), 64'd0);
        chk("ovf_valid", valid, mv);
`ifdef MATCH_OVF_EN
        chk("ovf_out_req", 64'(out_req), 64'd1);
        chk("ovf_err", 64'(err), 64'd0);
`else
        chk("drop_no_out_req", 64'(out_req), 64'd0);
        chk("drop_err", 64'(err), 64'd1);
        @(negedge clk);
        chk("drop_no_out_req_t3", 64'(out_req), 64'd0);
`endif
      end
    endcase
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_outs"}, 64'({in_ack, wr_e, rd_e, del, out_req, out_pair, out_ovf, full, err}),
        64'd0);
    chk({tag, "_valid"}, valid, 64'd0);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_addr"}, 64'(addr), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mr_n = 1'b0; in_req = 1'b0; in_mf = 1'b0; fire = '0; out_ack = 1'b1; mv = '0;
    #22;
    chk_reset_state("reset");
    @(negedge clk);
    mr_n = 1'b1;

    // First wait token allocates entry 0.
    issue(1'b1, 64'h0, KWrite, 0);
    // Build VALID=0x5: allocate 1 and 2, then match entry 1.
    issue(1'b1, 64'h0, KWrite, 1);
    issue(1'b1, 64'h0, KWrite, 2);
    sb.push_back('{pair: 1'b1, ovf: 1'b0});
    issue(1'b1, 64'h2, KRead, 1);
    chk("valid_is_5", valid, 64'h5);
    sb.push_back('{pair: 1'b1, ovf: 1'b0});
    issue(1'b1, 64'h4, KRead, 2);
    chk("valid_is_1", valid, 64'h1);

    // Build VALID=0x30.
    for (int i = 1; i < 6; i++) issue(1'b1, 64'h0, KWrite, i);
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{pair: 1'b1, ovf: 1'b0});
      issue(1'b1, 64'h1 << i, KRead, i);
    end
    chk("valid_is_30", valid, 64'h30);
    sb.push_back('{pair: 1'b1, ovf: 1'b0});
    issue(1'b1, 64'h30, KRead, 4);
    chk("valid_is_20", valid, 64'h20);

    // A hit on an invalid entry counts as a miss.
    issue(1'b1, 64'h1, KWrite, 0);
    chk("valid_is_21", valid, 64'h21);

    // Pass-through ignores FIRE.
    sb.push_back('{pair: 1'b0, ovf: 1'b0});
    issue(1'b0, 64'h1, KPass, 0);
    chk("pass_valid_kept", valid, 64'h21);

    // Fill the memory.
    while (mv != '1 && checks < 5000) issue(1'b1, 64'h0, KWrite, low_free(mv));
    @(negedge clk);
    chk("full_flag", 64'(full), 64'd1);
    chk("full_count", 64'(count), 64'd64);

`ifdef MATCH_OVF_EN
    sb.push_back('{pair: 1'b0, ovf: 1'b1});
`endif
    issue(1'b1, 64'h0, KOvf, 0);
    chk("still_full", 64'(count), 64'd64);

    // Multiple hits: lowest wins, the other stays valid.
    sb.push_back('{pair: 1'b1, ovf: 1'b0});
    issue(1'b1, 64'h8000_0000_0000_0100, KRead, 8);
    chk("multi_hit_bit63_kept", 64'(valid[63]), 64'd1);
    @(negedge clk);
    chk("not_full", 64'(full), 64'd0);

    // Downstream stall with a pending upstream token, then reset mid-EMIT.
    sb.push_back('{pair: 1'b0, ovf: 1'b0});
    out_ack = 1'b0;
    issue(1'b0, 64'h0, KPass, 0);
    in_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_hold", 64'({out_req, in_ack, out_pair}), 64'b100);
    end
    #2;
    mr_n = 1'b0;
    #1;
    chk_reset_state("mid_emit_reset");
    sb.delete();
    mv = '0;
    in_req = 1'b0;
    out_ack = 1'b1;
    @(negedge clk);
    mr_n = 1'b1;
    issue(1'b1, 64'h0, KWrite, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
